// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: start/parity/stop checks, per-frame valid/err pulse, sticky flags, optional counters (UART_ERR_CNT_EN).
// Flags and pulses are registered one cycle after their strobe. There is no backpressure: one check strobe is accepted every cycle.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sampled_bit,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  strt_chk_en,
  input  logic                  par_chk_en,
  input  logic                  stp_chk_en,
  input  logic                  frame_done,
  input  logic                  clr_err,
  output logic                  strt_err,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [2:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  logic exp_par;
  logic strt_nxt, par_nxt, stp_nxt;
  logic chk_any, any_err;

  always_comb begin
    exp_par = 1'b0;
    case (PAR_TYP)
      2'b00:   exp_par = ^P_DATA;
      2'b01:   exp_par = ~^P_DATA;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // A flag's own strobe beats the new-frame clear from strt_chk_en.
  always_comb begin
    strt_nxt = strt_chk_en ? sampled_bit : strt_err;
    par_nxt  = (par_chk_en && PAR_EN) ? (sampled_bit != exp_par)
             : (strt_chk_en ? 1'b0 : par_err);
    stp_nxt  = stp_chk_en ? ~sampled_bit : (strt_chk_en ? 1'b0 : stp_err);
    chk_any  = strt_chk_en | (par_chk_en & PAR_EN) | stp_chk_en;
    any_err  = strt_nxt | par_nxt | stp_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      strt_err    <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      strt_err    <= strt_nxt;
      par_err     <= par_nxt;
      stp_err     <= stp_nxt;
      frame_valid <= frame_done & ~any_err;
      frame_err   <= frame_done & any_err;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_sticky <= 3'b000;
    end else if (clr_err) begin
      err_sticky <= 3'b000;
    end else if (chk_any) begin
      err_sticky <= err_sticky | {stp_nxt, par_nxt, strt_nxt};
    end
  end

`ifdef UART_ERR_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] par_cnt_q, stp_cnt_q;

  // Saturating counters; clr_err wins over a same-cycle increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else if (clr_err) begin
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else if (frame_done) begin
      if (par_nxt && (par_cnt_q != CNT_MAX)) par_cnt_q <= par_cnt_q + CNT_ONE;
      if (stp_nxt && (stp_cnt_q != CNT_MAX)) stp_cnt_q <= stp_cnt_q + CNT_ONE;
    end
  end

  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
`else
  assign par_err_cnt = '0;
  assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: vector table, directed corner sequences and a random run against a frame-level model.
module tb_uart_rx_frame_check;

`ifdef UART_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CMAX = 3;  // CNT_WIDTH = 2

  logic       CLK, RST;
  logic       sampled_bit, PAR_EN;
  logic [7:0] P_DATA;
  logic [1:0] PAR_TYP;
  logic       strt_chk_en, par_chk_en, stp_chk_en, frame_done, clr_err;
  logic       strt_err, par_err, stp_err, frame_valid, frame_err;
  logic [2:0] err_sticky;
  logic [1:0] par_err_cnt, stp_err_cnt;

  uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .frame_done(frame_done),
    .clr_err(clr_err), .strt_err(strt_err), .par_err(par_err), .stp_err(stp_err),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_sticky(err_sticky),
    .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state, derived from the frame rules
  logic       m_strt, m_par, m_stp, m_fv, m_fe;
  logic [2:0] m_sticky;
  int         m_pcnt, m_scnt;

  typedef struct {
    logic       strt, par, stp, done, bv, en;
    logic [1:0] typ;
    logic       e_strt, e_par, e_stp, e_fv, e_fe;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_strt = 0; m_par = 0; m_stp = 0; m_fv = 0; m_fe = 0;
    m_sticky = 3'b000; m_pcnt = 0; m_scnt = 0;
  endtask

  task automatic model_update();
    logic par_of_data, e, ns, np, nt, bad;
    par_of_data = ($countones(P_DATA) % 2) == 1;
    case (PAR_TYP)
      2'd0: e = par_of_data;
      2'd1: e = !par_of_data;
      2'd2: e = 1'b1;
      default: e = 1'b0;
    endcase
    ns = strt_chk_en ? sampled_bit : m_strt;
    if (par_chk_en && PAR_EN) np = (sampled_bit != e);
    else                      np = strt_chk_en ? 1'b0 : m_par;
    nt = stp_chk_en ? !sampled_bit : (strt_chk_en ? 1'b0 : m_stp);
    bad = ns || np || nt;
    m_fv = frame_done && !bad;
    m_fe = frame_done && bad;
    if (clr_err) begin
      m_sticky = 3'b000; m_pcnt = 0; m_scnt = 0;
    end else begin
      if (strt_chk_en || (par_chk_en && PAR_EN) || stp_chk_en)
        m_sticky = m_sticky | {nt, np, ns};
      if (frame_done && np) m_pcnt = (m_pcnt < CMAX) ? m_pcnt + 1 : CMAX;
      if (frame_done && nt) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end
    m_strt = ns; m_par = np; m_stp = nt;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".strt_err"},    8'(strt_err),    8'(m_strt));
    chk({tag, ".par_err"},     8'(par_err),     8'(m_par));
    chk({tag, ".stp_err"},     8'(stp_err),     8'(m_stp));
    chk({tag, ".frame_valid"}, 8'(frame_valid), 8'(m_fv));
    chk({tag, ".frame_err"},   8'(frame_err),   8'(m_fe));
    chk({tag, ".err_sticky"},  8'(err_sticky),  8'(m_sticky));
    chk({tag, ".par_err_cnt"}, 8'(par_err_cnt), CNT_EN ? 8'(m_pcnt) : 8'd0);
    chk({tag, ".stp_err_cnt"}, 8'(stp_err_cnt), CNT_EN ? 8'(m_scnt) : 8'd0);
  endtask

  task automatic idle_inputs();
    strt_chk_en = 0; par_chk_en = 0; stp_chk_en = 0; frame_done = 0; clr_err = 0;
  endtask

  // Inputs are stable at the edge; outputs are sampled 1 ns after it.
  task automatic step(input string tag);
    @(posedge CLK);
    model_update();
    #1;
    compare_all(tag);
    idle_inputs();
  endtask

  task automatic strobe(input string tag, input logic s, input logic p, input logic t,
                        input logic d, input logic b, input logic c);
    strt_chk_en = s; par_chk_en = p; stp_chk_en = t; frame_done = d;
    sampled_bit = b; clr_err = c;
    step(tag);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, p, t, d, b, en, input logic [1:0] typ,
                              input logic es, ep, et, ev, ee);
    vec_t v;
    v.strt = s; v.par = p; v.stp = t; v.done = d; v.bv = b; v.en = en; v.typ = typ;
    v.e_strt = es; v.e_par = ep; v.e_stp = et; v.e_fv = ev; v.e_fe = ee;
    return v;
  endfunction

  initial begin
    //              strt par stp done bit en typ   strt par stp fv fe
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 2'd0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 1, 2'd0,  0, 0, 0, 0, 0);  // even, bit 0: ok
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 2'd0,  0, 1, 0, 0, 0);  // even, bit 1: err
    tbl[3]  = mk(0, 1, 0, 0, 1, 1, 2'd1,  0, 0, 0, 0, 0);  // odd, bit 1: ok
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 2'd2,  0, 1, 0, 0, 0);  // mark, bit 0: err
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 2'd0,  0, 0, 0, 0, 0);  // new frame clears par
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 2'd2,  0, 0, 0, 0, 0);  // PAR_EN=0 ignored
    tbl[7]  = mk(0, 0, 1, 1, 1, 1, 2'd0,  0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 2'd0,  0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 2'd0,  1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 0, 1, 2'd0,  1, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 2'd0,  1, 0, 1, 0, 1);
    tbl[12] = mk(1, 1, 0, 0, 1, 1, 2'd0,  1, 1, 0, 0, 0);  // par strobe beats clear
    tbl[13] = mk(0, 0, 1, 1, 1, 1, 2'd0,  1, 1, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 1, 1, 2'd0,  1, 1, 0, 0, 1);  // back-to-back done

    idle_inputs();
    sampled_bit = 0; P_DATA = 8'hA5; PAR_EN = 1; PAR_TYP = 2'd0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    compare_all("reset");

    for (int i = 0; i < 15; i++) begin
      PAR_EN = tbl[i].en; PAR_TYP = tbl[i].typ; P_DATA = 8'hA5;
      strobe($sformatf("vec%0d", i), tbl[i].strt, tbl[i].par, tbl[i].stp,
             tbl[i].done, tbl[i].bv, 1'b0);
      chk($sformatf("vec%0d.strt", i), 8'(strt_err),    8'(tbl[i].e_strt));
      chk($sformatf("vec%0d.par",  i), 8'(par_err),     8'(tbl[i].e_par));
      chk($sformatf("vec%0d.stp",  i), 8'(stp_err),     8'(tbl[i].e_stp));
      chk($sformatf("vec%0d.fv",   i), 8'(frame_valid), 8'(tbl[i].e_fv));
      chk($sformatf("vec%0d.fe",   i), 8'(frame_err),   8'(tbl[i].e_fe));
    end

    // Asynchronous reset mid-frame with par_err set
    PAR_EN = 1; PAR_TYP = 2'd0;
    strobe("arst_pre0", 1, 0, 0, 0, 0, 0);
    strobe("arst_pre1", 0, 1, 0, 0, 1, 0);
    chk("arst_par_set", 8'(par_err), 8'd1);
    #3 RST = 1'b1;
    model_reset();
    #1 compare_all("arst_async");
    @(posedge CLK);
    #1 RST = 1'b0;
    strobe("post_rst0", 1, 0, 0, 0, 0, 0);
    strobe("post_rst1", 0, 0, 1, 1, 1, 0);
    chk("post_rst_fv", 8'(frame_valid), 8'd1);

    // Framing errors
    do_reset();
    PAR_EN = 0;
    strobe("frm0", 1, 0, 0, 0, 1, 0);
    chk("frm_strt_err", 8'(strt_err), 8'd1);
    strobe("frm1", 0, 0, 1, 0, 0, 0);
    chk("frm_stp_err", 8'(stp_err), 8'd1);
    chk("frm_sticky", 8'(err_sticky), 8'b101);
    chk("frm_cnt_before", 8'(stp_err_cnt), 8'd0);
    strobe("frm2", 0, 0, 0, 1, 0, 0);
    chk("frm_fe", 8'(frame_err), 8'd1);
    chk("frm_fv", 8'(frame_valid), 8'd0);
    chk("frm_stp_cnt", 8'(stp_err_cnt), CNT_EN ? 8'd1 : 8'd0);

    // Stop check and completion in the same cycle
    strobe("same0", 1, 0, 0, 0, 0, 0);
    strobe("same1", 0, 0, 1, 1, 0, 0);
    chk("same_fe", 8'(frame_err), 8'd1);
    chk("same_fv", 8'(frame_valid), 8'd0);

    // Counter saturation, then clear racing a sixth error frame
    do_reset();
    PAR_EN = 1; PAR_TYP = 2'd0; P_DATA = 8'hA5;
    for (int f = 0; f < 5; f++) begin
      strobe("sat_s", 1, 0, 0, 0, 0, 0);
      strobe("sat_p", 0, 1, 0, 0, 1, 0);
      strobe("sat_d", 0, 0, 1, 1, 1, 0);
    end
    chk("sat_par_cnt", 8'(par_err_cnt), CNT_EN ? 8'd3 : 8'd0);
    strobe("clr_s", 1, 0, 0, 0, 0, 0);
    strobe("clr_p", 0, 1, 0, 0, 1, 0);
    strobe("clr_d", 0, 0, 1, 1, 1, 1);
    chk("clr_par_cnt", 8'(par_err_cnt), 8'd0);
    chk("clr_sticky", 8'(err_sticky), 8'd0);
    chk("clr_fe", 8'(frame_err), 8'd1);
    chk("clr_keeps_par", 8'(par_err), 8'd1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      strt_chk_en = ($urandom_range(0, 3) == 0);
      par_chk_en  = ($urandom_range(0, 3) == 0);
      stp_chk_en  = ($urandom_range(0, 3) == 0);
      frame_done  = ($urandom_range(0, 4) == 0);
      clr_err     = ($urandom_range(0, 19) == 0);
      sampled_bit = 1'($urandom);
      PAR_EN      = ($urandom_range(0, 3) != 0);
      PAR_TYP     = 2'($urandom);
      P_DATA      = 8'($urandom);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
